// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Round-robin arbiter that owns the single write path of the register bank.
// Requesters present level-sensitive write requests, each with a 4-bit target
// address and a data word. At most one winner is picked per cycle. The winner
// drives the per-register enable lines and the shared D bus, and both are
// registered. The bank therefore captures the write on the edge after the
// grant cycle begins.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   req       [NUM_REQ]          write request per requester (level)
//   req_addr  [NUM_REQ*4]        packed addresses, requester i at [4i+3:4i]
//   req_data  [NUM_REQ*DATA_W]   packed data, requester i at slice i
//   gnt       [NUM_REQ]          registered one-hot grant, one cycle per write
//   reg_en    [NUM_REGS]         registered one-hot write enable to the bank
//   reg_d     [DATA_W]           registered shared write data to the bank
//   idle      registered, 1 when no grant was issued at the last edge
//
// Configuration macro:
//   REGARB_R0_ZERO_EN  when defined, register 0 is hardwired to zero.
//                      A write to register 0 still takes its grant and turn,
//                      but reg_en[0] is never asserted.

module regfile_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*4-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REGS-1:0]         reg_en,
    output logic [DATA_W-1:0]           reg_d,
    output logic                        idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]    last_ptr;

    logic [NUM_REQ-1:0]  elig_p0;
    logic                win_vld_p0;
    logic [PTR_W-1:0]    win_idx_p0;
    logic [3:0]          win_addr_p0;
    logic [DATA_W-1:0]   win_data_p0;
    logic [NUM_REQ-1:0]  gnt_p0;
    logic [NUM_REGS-1:0] en_p0;

    // Stage p0: winner selection and decode (combinational, from sampled inputs).
    // A requester whose grant is high right now is masked, so a req that is
    // still held in its grant cycle is not written twice.
    assign elig_p0 = req & ~gnt;

    always_comb begin
        win_vld_p0 = 1'b0;
        win_idx_p0 = '0;
        // Search last_ptr+1, last_ptr+2, ... wrapping modulo NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_ptr) + k) % NUM_REQ;
            if (!win_vld_p0 && elig_p0[idx]) begin
                win_vld_p0 = 1'b1;
                win_idx_p0 = PTR_W'(idx);
            end
        end
    end

    assign win_addr_p0 = req_addr[int'(win_idx_p0)*4 +: 4];
    assign win_data_p0 = req_data[int'(win_idx_p0)*DATA_W +: DATA_W];

    always_comb begin
        gnt_p0 = '0;
        en_p0  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_p0[i] = win_vld_p0 && (int'(win_idx_p0) == i);
        end
        // An address with no matching register leaves every enable low, so
        // out-of-range writes are granted and silently dropped.
        for (int r = 0; r < NUM_REGS; r++) begin
            en_p0[r] = win_vld_p0 && (int'(win_addr_p0) == r);
        end
`ifdef REGARB_R0_ZERO_EN
        en_p0[0] = 1'b0;
`else
`endif
    end

    // Stage p1: registered grant, enables and data seen by the bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            reg_en   <= '0;
            reg_d    <= '0;
            idle     <= 1'b1;
            // Start just before requester 0 so it has top priority after reset.
            last_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (win_vld_p0) begin
            gnt      <= gnt_p0;
            reg_en   <= en_p0;
            reg_d    <= win_data_p0;
            idle     <= 1'b0;
            last_ptr <= win_idx_p0;
        end else begin
            gnt      <= '0;
            reg_en   <= '0;
            idle     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*4-1:0]       req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REGS-1:0]        reg_en;
    logic [DATA_W-1:0]          reg_d;
    logic                       idle;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .gnt     (gnt),
        .reg_en  (reg_en),
        .reg_d   (reg_d),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
        req_addr[i*4 +: 4]           = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic [15:0] en,
                            input logic [15:0] d, input logic i);
        chk({tag, ".gnt"},    32'(gnt),    32'(g));
        chk({tag, ".reg_en"}, 32'(reg_en), 32'(en));
        chk({tag, ".reg_d"},  32'(reg_d),  32'(d));
        chk({tag, ".idle"},   32'(idle),   32'(i));
    endtask

    logic [3:0]  exp_g [4];
    logic [15:0] exp_e [4];
    logic [15:0] exp_d [4];

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;

        // Reset then idle
        step(); step();
        chk_outs("reset", 4'b0000, 16'h0000, 16'h0000, 1'b1);
        reset = 1'b0;
        step();
        chk_outs("idle_after_reset", 4'b0000, 16'h0000, 16'h0000, 1'b1);

        // Single write: requester 2 -> reg 5
        set_req(2, 4'd5, 16'hBEEF);
        req = 4'b0100;
        step();
        chk_outs("single", 4'b0100, 16'h0020, 16'hBEEF, 1'b0);
        step();  // req still held in grant cycle: masked
        chk_outs("single_held", 4'b0000, 16'h0000, 16'hBEEF, 1'b1);
        req = 4'b0000;
        step();
        chk_outs("single_drop", 4'b0000, 16'h0000, 16'hBEEF, 1'b1);

        // Round-robin from reset priority
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 16'hA000 + 16'(i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            step();
            chk_outs($sformatf("rr%0d", k), 4'(1 << w), 16'(1 << (w + 1)),
                     16'hA000 + 16'(w), 1'b0);
            chk($sformatf("rr%0d.onehot", k), 32'($countones(gnt)), 32'd1);
        end

        // Mask and back-to-back: requesters 1 and 3 alternate every cycle
        set_req(1, 4'd6, 16'hC001);
        set_req(3, 4'd8, 16'hC003);
        req = 4'b1010;
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        exp_e = '{16'h0040, 16'h0100, 16'h0040, 16'h0100};
        exp_d = '{16'hC001, 16'hC003, 16'hC001, 16'hC003};
        for (int k = 0; k < 4; k++) begin
            step();
            chk_outs($sformatf("alt%0d", k), exp_g[k], exp_e[k], exp_d[k], 1'b0);
        end
        // Requester 1 alone: granted every other cycle
        req = 4'b0010;
        exp_g = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("solo%0d.gnt", k), 32'(gnt), 32'(exp_g[k]));
        end

        // Reset mid-grant: last_ptr is 1, so requester 0 wins over requester 1
        set_req(0, 4'd7, 16'h7777);
        set_req(1, 4'd9, 16'h9999);
        req = 4'b0011;
        step();
        chk_outs("pre_reset", 4'b0001, 16'h0080, 16'h7777, 1'b0);
        reset = 1'b1;
        step();
        chk_outs("mid_reset", 4'b0000, 16'h0000, 16'h0000, 1'b1);
        reset = 1'b0;
        step();  // pointer back at NUM_REQ-1: requester 0 first again
        chk_outs("post_reset", 4'b0001, 16'h0080, 16'h7777, 1'b0);
        step();
        chk_outs("post_reset2", 4'b0010, 16'h0200, 16'h9999, 1'b0);

        // Write to register 0
        req = 4'b0000;
        step();
        set_req(0, 4'd0, 16'h1234);
        req = 4'b0001;
        step();
`ifdef REGARB_R0_ZERO_EN
        chk_outs("r0", 4'b0001, 16'h0000, 16'h1234, 1'b0);
`else
        chk_outs("r0", 4'b0001, 16'h0001, 16'h1234, 1'b0);
`endif
        req = 4'b0000;
        step();
        chk_outs("r0_done", 4'b0000, 16'h0000, 16'h1234, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
